// File: rtl/mlp_pkg.sv
// mlp_pkg: shared sizes, FSM state type and default Q8.8 network constants.
package mlp_pkg;
  localparam int W = 16;
  localparam int IN_N = 2;
  localparam int HID_N = 3;
  typedef enum logic [2:0] {IDLE, L1_MAC, L1_WB, L2_MAC, L2_WB, DONE} state_t;
  // Vectors are packed with element 0 in the least significant slot; W1 is row-major [j][k].
  localparam logic [IN_N*W-1:0] X = {16'h0200, 16'h0100};
  localparam logic [HID_N*IN_N*W-1:0] W1 = {16'hFF00, 16'hFF00, 16'h0080, 16'hFF00, 16'h0040, 16'h0080};
  localparam logic [HID_N*W-1:0] B1 = {16'h0000, 16'h0040, 16'h0000};
  localparam logic [HID_N*W-1:0] W2 = {16'h0100, 16'h0200, 16'h0100};
  localparam logic [W-1:0] B2 = 16'h0080;
endpackage

// File: rtl/mac_unit.sv
// mac_unit: signed multiply-accumulate with Q8.8 rescale and 16-bit saturation.
module mac_unit #(
  parameter int W = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  load,
  input  logic                  mac,
  input  logic signed [2*W-1:0] init,
  input  logic signed [W-1:0]   a,
  input  logic signed [W-1:0]   b,
  output logic        [W-1:0]   res
);
  localparam logic signed [2*W-1:0] MAXV = {{(W+1){1'b0}}, {(W-1){1'b1}}};
  localparam logic signed [2*W-1:0] MINV = ~MAXV;
  logic signed [2*W-1:0] acc, prod, sh;
  assign prod = (2*W)'(a) * (2*W)'(b);
  assign sh = acc >>> 8;
  assign res = sh > MAXV ? MAXV[W-1:0] : sh < MINV ? MINV[W-1:0] : sh[W-1:0];
  always_ff @(posedge clk)
    if (rst) acc <= '0;
    else if (load) acc <= init;
    else if (mac) acc <= acc + prod;
endmodule

// File: rtl/top.sv
// top: sequential IN_N -> HID_N -> 1 MLP inference on constant operands.
// Define MLP_RELU_EN to apply ReLU on the hidden layer (identity otherwise).
module top #(
  parameter int W = mlp_pkg::W,
  parameter int IN_N = mlp_pkg::IN_N,
  parameter int HID_N = mlp_pkg::HID_N,
  parameter logic [IN_N*W-1:0] X_C = mlp_pkg::X,
  parameter logic [HID_N*IN_N*W-1:0] W1_C = mlp_pkg::W1,
  parameter logic [HID_N*W-1:0] B1_C = mlp_pkg::B1,
  parameter logic [HID_N*W-1:0] W2_C = mlp_pkg::W2,
  parameter logic [W-1:0] B2_C = mlp_pkg::B2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         run,
  output logic [W-1:0] out,
  output logic         finished
);
  import mlp_pkg::*;
  state_t state;
  logic [31:0] j, k;
  logic [HID_N*W-1:0] h;
  logic signed [2*W-1:0] init;
  logic signed [W-1:0] a, b;
  logic [W-1:0] res, act;
  logic load, mac;
  function automatic logic signed [2*W-1:0] q16(input logic [W-1:0] v);
    return {{W{v[W-1]}}, v} << 8;
  endfunction
`ifdef MLP_RELU_EN
  assign act = res[W-1] ? '0 : res;
`else
  assign act = res;
`endif
  // Bias for the next neuron (or the output layer) is preloaded on each writeback.
  assign load = (state == IDLE && run) || state == L1_WB;
  assign mac = state == L1_MAC || state == L2_MAC;
  assign init = state == IDLE ? q16(B1_C[W-1:0]) : j == HID_N - 1 ? q16(B2_C) : q16(B1_C[(j+1)*W +: W]);
  assign a = state == L2_MAC ? h[k*W +: W] : X_C[k*W +: W];
  assign b = state == L2_MAC ? W2_C[k*W +: W] : W1_C[(j*IN_N+k)*W +: W];
  mac_unit #(.W(W)) u_mac (
    .clk(clk), .rst(rst), .load(load), .mac(mac), .init(init), .a(a), .b(b), .res(res)
  );
  always_ff @(posedge clk)
    if (rst) begin
      state <= IDLE;
      j <= '0;
      k <= '0;
      h <= '0;
      out <= '0;
      finished <= 1'b0;
    end else if (!run) begin
      state <= IDLE;
      j <= '0;
      k <= '0;
      finished <= 1'b0;
    end else
      case (state)
        IDLE: begin
          state <= L1_MAC;
          j <= '0;
          k <= '0;
        end
        L1_MAC: begin
          k <= k + 1;
          if (k == IN_N - 1) state <= L1_WB;
        end
        L1_WB: begin
          h[j*W +: W] <= act;
          k <= '0;
          j <= j == HID_N - 1 ? '0 : j + 1;
          state <= j == HID_N - 1 ? L2_MAC : L1_MAC;
        end
        L2_MAC: begin
          k <= k + 1;
          if (k == HID_N - 1) state <= L2_WB;
        end
        L2_WB: begin
          out <= res;
          finished <= 1'b1;
          state <= DONE;
        end
        default: state <= DONE;
      endcase
endmodule

// File: tb/tb_top.sv
// tb_top: directed and random run/rst sequences against a transaction-level MLP model.
module tb_top;
  logic clk = 1'b0, rst = 1'b0, run = 1'b0;
  logic [15:0] out0, out1, out2;
  logic fin0, fin1, fin2;
  int total = 0, bad = 0, streak = 0;
  logic [15:0] m_out [3];
  logic [15:0] expv [3];
  logic m_fin = 1'b0;
  always #5 clk = ~clk;
  top dut (.clk(clk), .rst(rst), .run(run), .out(out0), .finished(fin0));
  top #(.W2_C({16'h0100, 16'h7FFF, 16'h7FFF})) dut_pos (.clk(clk), .rst(rst), .run(run), .out(out1), .finished(fin1));
  top #(.W2_C({16'h0100, 16'h8000, 16'h8000})) dut_neg (.clk(clk), .rst(rst), .run(run), .out(out2), .finished(fin2));
  function automatic int sat(input int v);
    return v > 32767 ? 32767 : v < -32768 ? -32768 : v;
  endfunction
  // Network evaluated directly in integer Q8.8 arithmetic; >>> on int floors.
  function automatic logic [15:0] infer(input int w2 [3]);
    int x [2] = '{256, 512};
    int w1 [3][2] = '{'{128, 64}, '{-256, 128}, '{-256, -256}};
    int b1 [3] = '{0, 64, 0};
    int hv [3];
    int acc;
    for (int jj = 0; jj < 3; jj++) begin
      acc = b1[jj] * 256;
      for (int kk = 0; kk < 2; kk++) acc += x[kk] * w1[jj][kk];
      hv[jj] = sat(acc >>> 8);
`ifdef MLP_RELU_EN
      if (hv[jj] < 0) hv[jj] = 0;
`endif
    end
    acc = 128 * 256;
    for (int jj = 0; jj < 3; jj++) acc += hv[jj] * w2[jj];
    return 16'(sat(acc >>> 8));
  endfunction
  task automatic chk(input string name, input logic [15:0] got, input logic [15:0] want);
    total++;
    assert (got === want) else begin
      bad++;
      $error("FAIL %s got=%h exp=%h", name, got, want);
    end
  endtask
  // The result appears on the 14th consecutive run-high edge counted from IDLE.
  task automatic step(input logic r, input logic rs);
    run = r;
    rst = rs;
    @(posedge clk);
    if (rs) begin
      streak = 0;
      m_fin = 1'b0;
      m_out = '{16'h0, 16'h0, 16'h0};
    end else if (!r) begin
      streak = 0;
      m_fin = 1'b0;
    end else begin
      streak++;
      if (streak == 14) begin
        m_fin = 1'b1;
        m_out = expv;
      end
    end
    #1;
    chk("out", out0, m_out[0]);
    chk("finished", {15'h0, fin0}, {15'h0, m_fin});
    chk("out_pos", out1, m_out[1]);
    chk("fin_pos", {15'h0, fin1}, {15'h0, m_fin});
    chk("out_neg", out2, m_out[2]);
    chk("fin_neg", {15'h0, fin2}, {15'h0, m_fin});
  endtask
  initial begin
    m_out = '{16'h0, 16'h0, 16'h0};
    expv[0] = infer('{256, 512, 256});
    expv[1] = infer('{32767, 32767, 256});
    expv[2] = infer('{-32768, -32768, 256});
    step(0, 1);
    step(0, 1);
    step(0, 0);
    for (int i = 0; i < 40; i++) step(1, 0);
`ifdef MLP_RELU_EN
    chk("spec_out", out0, 16'h0200);
`else
    chk("spec_out", out0, 16'hFF00);
`endif
    chk("spec_pos_sat", out1, 16'h7FFF);
    chk("spec_neg_sat", out2, 16'h8000);
    for (int i = 0; i < 4; i++) step(0, 0);
    for (int i = 0; i < 40; i++) step(1, 0);
    step(0, 0);
    for (int i = 0; i < 5; i++) step(1, 0);
    for (int i = 0; i < 3; i++) step(0, 0);
    for (int i = 0; i < 7; i++) step(1, 0);
    step(1, 1);
    step(0, 0);
    chk("abort_rst_out", out0, 16'h0000);
    for (int i = 0; i < 400; i++) step($urandom_range(0, 15) != 0, $urandom_range(0, 63) == 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
